ks_addsub_pipe: RTL

//  Parametrised, pipelined Kogge-Stone adder/subtractor for the FFT butterfly datapath.

---
 rtl/ks_addsub_pipe_pkg.sv | 46 ++++
 rtl/ks_addsub_pipe_if.sv | 30 +++
 rtl/ks_prefix_cell.sv | 18 +
 rtl/ks_addsub_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ks_addsub_pipe_pkg.sv
// Shared types and elaboration-time helpers for the Kogge-Stone add/sub pipeline.
//  - ks_side_t : per-operation sideband carried alongside the prefix data
//  - ks_clog2/ks_levels/ks_nseg/ks_lat : prefix-tree depth and pipeline latency
//  - ks_sat_max/ks_sat_min : signed saturation limits for a given width
package ks_addsub_pipe_pkg;

    typedef struct packed {
        logic cin;    // effective carry-in (already inverted for subtract)
        logic a_msb;  // sign of operand A
        logic b_msb;  // sign of effective operand B
    } ks_side_t;

    // Ceiling log2, valid for v >= 1.
    function automatic int unsigned ks_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned ks_levels(input int unsigned width);
        return ks_clog2(width);
    endfunction

    // Number of registered prefix segments after the P/G stage.
    function automatic int unsigned ks_nseg(input int unsigned width, input int unsigned reg_every);
        return (ks_levels(width) + reg_every - 1) / reg_every;
    endfunction

    function automatic int unsigned ks_lat(input int unsigned width, input int unsigned reg_every);
        return 1 + ks_nseg(width, reg_every);
    endfunction

    function automatic logic [63:0] ks_sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] ks_sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/ks_addsub_pipe_if.sv
// Operand/result handshake bundle for ks_addsub_pipe.
//  Upstream : i_valid, o_ready, i_sub, i_c0, i_a, i_b
//  Downstream: o_valid, i_ready, o_sum, o_cout, o_ovf
//  slave  = the adder/subtractor; master = the block driving operands and consuming results.
interface ks_addsub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic             i_sub;
    logic             i_c0;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_sub, i_c0, i_a, i_b, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );

    modport master (
        output i_valid, i_sub, i_c0, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );

endinterface

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: merges a high group (gh_i, ph_i) with the adjacent lower
// group (gl_i, pl_i) into the combined generate/propagate pair.
//  gh_i/ph_i : generate/propagate of the upper group
//  gl_i/pl_i : generate/propagate of the lower group
//  g_o/p_o   : combined group generate/propagate
module ks_prefix_cell (
    input  logic gh_i,
    input  logic ph_i,
    input  logic gl_i,
    input  logic pl_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gh_i | (ph_i & gl_i);
    assign p_o = ph_i & pl_i;

endmodule

// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and global stall.
//  Parameters: WIDTH (power of two, 4..64), REG_EVERY (prefix levels per register, 1..clog2(WIDTH)).
//  Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus (slave)  : operands i_a/i_b/i_sub/i_c0 with i_valid/o_ready,
//                  result o_sum/o_cout/o_ovf with o_valid/i_ready
//  Latency 1 + ceil(clog2(WIDTH)/REG_EVERY) cycles, one op per cycle when not stalled.
//  Build option: define KS_ADDSUB_SAT_EN to saturate o_sum on signed overflow.
module ks_addsub_pipe
    import ks_addsub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_EVERY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ks_addsub_pipe_if.slave      bus
);

    localparam int unsigned LEVELS = ks_levels(WIDTH);
    localparam int unsigned NSEG   = ks_nseg(WIDTH, REG_EVERY);

    // Stage 0 holds the bitwise P/G; stage s holds the prefix result after segment s.
    logic [NSEG:0]    v_q;
    logic [NSEG:0]    v_d;
    logic [WIDTH-1:0] g_q  [0:NSEG];
    logic [WIDTH-1:0] gp_q [0:NSEG];
    logic [WIDTH-1:0] p_q  [0:NSEG];
    ks_side_t         side_q [0:NSEG];

    logic [WIDTH-1:0] g_d  [1:NSEG];
    logic [WIDTH-1:0] gp_d [1:NSEG];

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p0_d;
    logic [WIDTH-1:0] g0_d;
    ks_side_t         side0_d;

    // Whole pipe advances together; it only holds when a result is stuck at the output.
    assign en          = ~v_q[NSEG] | bus.i_ready;
    assign bus.o_ready = en;
    assign bus.o_valid = v_q[NSEG];

    // Operand conditioning and bitwise P/G; carry-in folded into bit 0 generate.
    always_comb begin
        b_eff         = bus.i_sub ? ~bus.i_b : bus.i_b;
        side0_d       = '0;
        side0_d.cin   = bus.i_sub ? ~bus.i_c0 : bus.i_c0;
        side0_d.a_msb = bus.i_a[WIDTH-1];
        side0_d.b_msb = b_eff[WIDTH-1];
        p0_d          = bus.i_a ^ b_eff;
        g0_d          = bus.i_a & b_eff;
        g0_d[0]       = g0_d[0] | (p0_d[0] & side0_d.cin);
    end

    // Valid bits shift one stage per enabled cycle.
    always_comb begin
        v_d = {v_q[NSEG-1:0], bus.i_valid};
    end

    // Prefix tree: each level reads either a stage register (segment start) or the previous level.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned SPAN = 1 << l;
        logic [WIDTH-1:0] gin;
        logic [WIDTH-1:0] pin;
        logic [WIDTH-1:0] gout;
        logic [WIDTH-1:0] pout;

        if ((l % REG_EVERY) == 0) begin : g_src_reg
            assign gin = g_q[l / REG_EVERY];
            assign pin = gp_q[l / REG_EVERY];
        end else begin : g_src_comb
            assign gin = g_lvl[l-1].gout;
            assign pin = g_lvl[l-1].pout;
        end

        for (genvar k = 0; k < WIDTH; k++) begin : g_bit
            if (k >= SPAN) begin : g_cell
                ks_prefix_cell u_cell (
                    .gh_i (gin[k]),
                    .ph_i (pin[k]),
                    .gl_i (gin[k-SPAN]),
                    .pl_i (pin[k-SPAN]),
                    .g_o  (gout[k]),
                    .p_o  (pout[k])
                );
            end else begin : g_pass
                assign gout[k] = gin[k];
                assign pout[k] = pin[k];
            end
        end
    end

    // Each segment register captures the last level of its segment; the final level is always registered.
    for (genvar s = 1; s <= NSEG; s++) begin : g_stage
        localparam int unsigned LAST = (((s * REG_EVERY) < LEVELS) ? (s * REG_EVERY) : LEVELS) - 1;
        assign g_d[s]  = g_lvl[LAST].gout;
        assign gp_d[s] = g_lvl[LAST].pout;
    end

    // Pipeline registers: reset flushes everything, stall holds everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q <= '0;
            for (int unsigned s = 0; s <= NSEG; s++) begin
                g_q[s]    <= '0;
                gp_q[s]   <= '0;
                p_q[s]    <= '0;
                side_q[s] <= '0;
            end
        end else if (en) begin
            v_q       <= v_d;
            g_q[0]    <= g0_d;
            gp_q[0]   <= p0_d;
            p_q[0]    <= p0_d;
            side_q[0] <= side0_d;
            for (int unsigned s = 1; s <= NSEG; s++) begin
                g_q[s]    <= g_d[s];
                gp_q[s]   <= gp_d[s];
                p_q[s]    <= p_q[s-1];
                side_q[s] <= side_q[s-1];
            end
        end
    end

    // Final group propagate is only needed inside the tree.
    logic unused_gp;
    assign unused_gp = ^gp_q[NSEG];

    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] sum_wrap_c;
    logic             ovf_c;

`ifdef KS_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(ks_sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(ks_sat_min(WIDTH));
`endif

    // Sum, carry and overflow straight off the final register.
    always_comb begin
        carry_c    = {g_q[NSEG][WIDTH-2:0], side_q[NSEG].cin};
        sum_wrap_c = p_q[NSEG] ^ carry_c;
        ovf_c      = (side_q[NSEG].a_msb == side_q[NSEG].b_msb) &
                     (sum_wrap_c[WIDTH-1] != side_q[NSEG].a_msb);
    end

    assign bus.o_cout = g_q[NSEG][WIDTH-1];
    assign bus.o_ovf  = ovf_c;

`ifdef KS_ADDSUB_SAT_EN
    // Overflow direction follows the sign of A (both effective operands share it).
    assign bus.o_sum = ovf_c ? (side_q[NSEG].a_msb ? SAT_MIN : SAT_MAX) : sum_wrap_c;
`else
    assign bus.o_sum = sum_wrap_c;
`endif

endmodule
